// File: rtl/de_stage_pkg.sv
// Shared decode definitions: widths, internal opcode/type enums and the DE latch layout
// that the AGEX stage unpacks.
package de_stage_pkg;

   localparam int DBITS      = 32;
   localparam int INSTBITS   = 32;
   localparam int REGNOBITS  = 5;
   localparam int IOPBITS    = 6;
   localparam int TYPENOBITS = 3;
   localparam int NREGS      = 32;

   typedef enum logic [IOPBITS-1:0] {
      NOP_I = 6'd0,
      LUI_I, AUIPC_I, JAL_I, JALR_I,
      BEQ_I, BNE_I, BLT_I, BGE_I, BLTU_I, BGEU_I,
      LB_I, LH_I, LW_I, LBU_I, LHU_I,
      SB_I, SH_I, SW_I,
      ADDI_I, SLTI_I, SLTIU_I, XORI_I, ORI_I, ANDI_I, SLLI_I, SRLI_I, SRAI_I,
      ADD_I, SUB_I, SLL_I, SLT_I, SLTU_I, XOR_I, SRL_I, SRA_I, OR_I, AND_I
   } op_e;

   typedef enum logic [TYPENOBITS-1:0] {
      R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, INV_TYPE
   } type_e;

   // Field order is the contract with AGEX; keep DE_LATCH_BITS in step with it.
   typedef struct packed {
      logic                 valid;
      logic [INSTBITS-1:0]  inst;
      logic [DBITS-1:0]     pc;
      logic [DBITS-1:0]     pcplus;
      op_e                  op;
      type_e                inst_type;
      logic [DBITS-1:0]     imm;
      logic [DBITS-1:0]     rs1_val;
      logic [DBITS-1:0]     rs2_val;
      logic [REGNOBITS-1:0] rd;
      logic                 wr_reg;
   } de_latch_t;

   localparam int DE_LATCH_BITS = 1 + INSTBITS + 5 * DBITS + IOPBITS + TYPENOBITS + REGNOBITS + 1;

endpackage

// File: rtl/de_stage_regfile.sv
// 32-entry architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero and a same-cycle write-to-read bypass.
module de_stage_regfile
   import de_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REGNOBITS-1:0] rd_addr1,
   input  logic [REGNOBITS-1:0] rd_addr2,
   output logic [DBITS-1:0]     rd_data1,
   output logic [DBITS-1:0]     rd_data2,
   input  logic                 wr_en,
   input  logic [REGNOBITS-1:0] wr_addr,
   input  logic [DBITS-1:0]     wr_data
);

   logic [DBITS-1:0] regs_q [NREGS];
   logic [DBITS-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (wr_en && wr_addr != '0) regs_d[wr_addr] = wr_data;
   end

   // NOTE: the array is reset because software may read registers before writing them;
   // this makes it a flop array, which is acceptable at 32 entries.
   always_ff @(posedge clk) begin
      if (reset) regs_q <= '{default: '0};
      else       regs_q <= regs_d;
   end

   assign rd_data1 = (rd_addr1 == '0)                   ? '0      :
                     (wr_en && wr_addr == rd_addr1)     ? wr_data : regs_q[rd_addr1];
   assign rd_data2 = (rd_addr2 == '0)                   ? '0      :
                     (wr_en && wr_addr == rd_addr2)     ? wr_data : regs_q[rd_addr2];

endmodule

// File: rtl/de_stage.sv
// Decode stage: RV32I decode, register read, RAW scoreboard with stall, and the DE latch.
module de_stage
   import de_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fe_valid,
   input  logic [INSTBITS-1:0]   fe_inst,
   input  logic [DBITS-1:0]      fe_pc,
   output logic                  de_stall,
   input  logic                  agex_br_taken,
   input  logic                  wb_wr_en,
   input  logic [REGNOBITS-1:0]  wb_rd,
   input  logic [DBITS-1:0]      wb_data,
   output logic                  de_valid,
   output logic [INSTBITS-1:0]   de_inst,
   output logic [DBITS-1:0]      de_pc,
   output logic [DBITS-1:0]      de_pcplus,
   output logic [IOPBITS-1:0]    de_op,
   output logic [TYPENOBITS-1:0] de_type,
   output logic [DBITS-1:0]      de_imm,
   output logic [DBITS-1:0]      de_rs1_val,
   output logic [DBITS-1:0]      de_rs2_val,
   output logic [REGNOBITS-1:0]  de_rd,
   output logic                  de_wr_reg
);

   logic [6:0]           opcode;
   logic [2:0]           funct3;
   logic [6:0]           funct7;
   logic [REGNOBITS-1:0] rs1, rs2, rd_f;
   logic [DBITS-1:0]     rs1_val, rs2_val;

   op_e                  dec_op;
   type_e                dec_type;
   logic                 known, uses_rs1, uses_rs2, writes, wr_reg;
   logic [DBITS-1:0]     dec_imm;
   logic                 hazard, issue;

   logic [NREGS-1:0]     busy_q, busy_d;
   de_latch_t            de_latch_q, de_latch_d;

   assign opcode = fe_inst[6:0];
   assign funct3 = fe_inst[14:12];
   assign funct7 = fe_inst[31:25];
   assign rs1    = fe_inst[19:15];
   assign rs2    = fe_inst[24:20];
   assign rd_f   = fe_inst[11:7];

   de_stage_regfile u_regfile (
      .clk      (clk),
      .reset    (reset),
      .rd_addr1 (rs1),
      .rd_addr2 (rs2),
      .rd_data1 (rs1_val),
      .rd_data2 (rs2_val),
      .wr_en    (wb_wr_en),
      .wr_addr  (wb_rd),
      .wr_data  (wb_data)
   );

   // NOTE: every output of this block gets a default first, so no path leaves a value
   // held and no latch is inferred.
   always_comb begin
      dec_op   = NOP_I;
      dec_type = INV_TYPE;
      known    = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      writes   = 1'b0;
      case (opcode)
         7'b0110111: begin dec_op = LUI_I;   dec_type = U_TYPE; known = 1'b1; writes = 1'b1; end
         7'b0010111: begin dec_op = AUIPC_I; dec_type = U_TYPE; known = 1'b1; writes = 1'b1; end
         7'b1101111: begin dec_op = JAL_I;   dec_type = J_TYPE; known = 1'b1; writes = 1'b1; end
         7'b1100111: begin
            dec_op = JALR_I; dec_type = I_TYPE; uses_rs1 = 1'b1; writes = 1'b1;
            known  = (funct3 == 3'b000);
         end
         7'b1100011: begin
            dec_type = B_TYPE; uses_rs1 = 1'b1; uses_rs2 = 1'b1; known = 1'b1;
            case (funct3)
               3'b000:  dec_op = BEQ_I;
               3'b001:  dec_op = BNE_I;
               3'b100:  dec_op = BLT_I;
               3'b101:  dec_op = BGE_I;
               3'b110:  dec_op = BLTU_I;
               3'b111:  dec_op = BGEU_I;
               default: known  = 1'b0;
            endcase
         end
         7'b0000011: begin
            dec_type = I_TYPE; uses_rs1 = 1'b1; writes = 1'b1; known = 1'b1;
            case (funct3)
               3'b000:  dec_op = LB_I;
               3'b001:  dec_op = LH_I;
               3'b010:  dec_op = LW_I;
               3'b100:  dec_op = LBU_I;
               3'b101:  dec_op = LHU_I;
               default: known  = 1'b0;
            endcase
         end
         7'b0100011: begin
            dec_type = S_TYPE; uses_rs1 = 1'b1; uses_rs2 = 1'b1; known = 1'b1;
            case (funct3)
               3'b000:  dec_op = SB_I;
               3'b001:  dec_op = SH_I;
               3'b010:  dec_op = SW_I;
               default: known  = 1'b0;
            endcase
         end
         7'b0010011: begin
            dec_type = I_TYPE; uses_rs1 = 1'b1; writes = 1'b1; known = 1'b1;
            case (funct3)
               3'b000: dec_op = ADDI_I;
               3'b010: dec_op = SLTI_I;
               3'b011: dec_op = SLTIU_I;
               3'b100: dec_op = XORI_I;
               3'b110: dec_op = ORI_I;
               3'b111: dec_op = ANDI_I;
               3'b001: begin dec_op = SLLI_I; known = (funct7 == 7'b0000000); end
               default: begin
                  dec_op = (funct7[5]) ? SRAI_I : SRLI_I;
                  known  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
               end
            endcase
         end
         7'b0110011: begin
            dec_type = R_TYPE; uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes = 1'b1; known = 1'b1;
            case ({funct7, funct3})
               10'b0000000_000: dec_op = ADD_I;
               10'b0100000_000: dec_op = SUB_I;
               10'b0000000_001: dec_op = SLL_I;
               10'b0000000_010: dec_op = SLT_I;
               10'b0000000_011: dec_op = SLTU_I;
               10'b0000000_100: dec_op = XOR_I;
               10'b0000000_101: dec_op = SRL_I;
               10'b0100000_101: dec_op = SRA_I;
               10'b0000000_110: dec_op = OR_I;
               10'b0000000_111: dec_op = AND_I;
               default:         known  = 1'b0;
            endcase
         end
         default: known = 1'b0;
      endcase
      if (!known) begin
         dec_op   = NOP_I;
         dec_type = INV_TYPE;
         uses_rs1 = 1'b0;
         uses_rs2 = 1'b0;
         writes   = 1'b0;
      end
   end

   always_comb begin
      dec_imm = '0;
      case (dec_type)
         I_TYPE:  dec_imm = {{20{fe_inst[31]}}, fe_inst[31:20]};
         S_TYPE:  dec_imm = {{20{fe_inst[31]}}, fe_inst[31:25], fe_inst[11:7]};
         B_TYPE:  dec_imm = {{19{fe_inst[31]}}, fe_inst[31], fe_inst[7], fe_inst[30:25],
                             fe_inst[11:8], 1'b0};
         U_TYPE:  dec_imm = {fe_inst[31:12], 12'b0};
         J_TYPE:  dec_imm = {{11{fe_inst[31]}}, fe_inst[31], fe_inst[19:12], fe_inst[20],
                             fe_inst[30:21], 1'b0};
         default: dec_imm = '0;
      endcase
   end

   assign wr_reg = writes && (rd_f != '0);

   // A WB write to a source this cycle is bypassed by the regfile, so it clears the hazard.
   assign hazard   = fe_valid &&
                     ((uses_rs1 && busy_q[rs1] && !(wb_wr_en && wb_rd == rs1)) ||
                      (uses_rs2 && busy_q[rs2] && !(wb_wr_en && wb_rd == rs2)));
   assign issue    = fe_valid && !hazard && !agex_br_taken;
   assign de_stall = !reset && hazard && !agex_br_taken;

   always_comb begin
      busy_d = busy_q;
      if (wb_wr_en)        busy_d[wb_rd] = 1'b0;
      if (issue && wr_reg) busy_d[rd_f]  = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      de_latch_d = '0;
      if (issue) begin
         de_latch_d.valid     = 1'b1;
         de_latch_d.inst      = fe_inst;
         de_latch_d.pc        = fe_pc;
         de_latch_d.pcplus    = fe_pc + DBITS'(4);
         de_latch_d.op        = dec_op;
         de_latch_d.inst_type = dec_type;
         de_latch_d.imm       = dec_imm;
         de_latch_d.rs1_val   = rs1_val;
         de_latch_d.rs2_val   = rs2_val;
         de_latch_d.rd        = writes ? rd_f : '0;
         de_latch_d.wr_reg    = wr_reg;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         de_latch_q <= '0;
         busy_q     <= '0;
      end else begin
         de_latch_q <= de_latch_d;
         busy_q     <= busy_d;
      end
   end

   assign de_valid   = de_latch_q.valid;
   assign de_inst    = de_latch_q.inst;
   assign de_pc      = de_latch_q.pc;
   assign de_pcplus  = de_latch_q.pcplus;
   assign de_op      = de_latch_q.op;
   assign de_type    = de_latch_q.inst_type;
   assign de_imm     = de_latch_q.imm;
   assign de_rs1_val = de_latch_q.rs1_val;
   assign de_rs2_val = de_latch_q.rs2_val;
   assign de_rd      = de_latch_q.rd;
   assign de_wr_reg  = de_latch_q.wr_reg;

endmodule

// File: tb/tb_de_stage.sv
// Directed bench for de_stage: decode fields, RAW stall/bypass, squash, x0 and reset behaviour.
module tb_de_stage;
   import de_stage_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  fe_valid;
   logic [INSTBITS-1:0]   fe_inst;
   logic [DBITS-1:0]      fe_pc;
   logic                  de_stall;
   logic                  agex_br_taken;
   logic                  wb_wr_en;
   logic [REGNOBITS-1:0]  wb_rd;
   logic [DBITS-1:0]      wb_data;
   logic                  de_valid;
   logic [INSTBITS-1:0]   de_inst;
   logic [DBITS-1:0]      de_pc, de_pcplus;
   logic [IOPBITS-1:0]    de_op;
   logic [TYPENOBITS-1:0] de_type;
   logic [DBITS-1:0]      de_imm, de_rs1_val, de_rs2_val;
   logic [REGNOBITS-1:0]  de_rd;
   logic                  de_wr_reg;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] ADDI_X1_X0_5   = 32'h0050_0093;
   localparam logic [31:0] ADD_X2_X1_X1   = 32'h0010_8133;
   localparam logic [31:0] ADDI_X3_X0_1   = 32'h0010_0193;
   localparam logic [31:0] ADD_X6_X2_X2   = 32'h0021_0333;
   localparam logic [31:0] ADD_X7_X0_X0   = 32'h0000_03B3;
   localparam logic [31:0] ADDI_X0_X0_1   = 32'h0010_0013;
   localparam logic [31:0] ADDI_X4_X0_7   = 32'h0070_0213;
   localparam logic [31:0] ADD_X8_X4_X1   = 32'h0012_0433;
   localparam logic [31:0] BEQ_X1_X2_M8   = 32'hFE20_8CE3;
   localparam logic [31:0] SW_X2_8_X1     = 32'h0020_A423;
   localparam logic [31:0] LUI_X5_12345   = 32'h1234_52B7;
   localparam logic [31:0] BAD_INST       = 32'hFFFF_FFFF;
   localparam logic [31:0] ADD_X9_X8_X8   = 32'h0084_04B3;
   localparam logic [31:0] ADD_X10_X1_X1  = 32'h0010_8533;

   de_stage dut (
      .clk           (clk),
      .reset         (reset),
      .fe_valid      (fe_valid),
      .fe_inst       (fe_inst),
      .fe_pc         (fe_pc),
      .de_stall      (de_stall),
      .agex_br_taken (agex_br_taken),
      .wb_wr_en      (wb_wr_en),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .de_valid      (de_valid),
      .de_inst       (de_inst),
      .de_pc         (de_pc),
      .de_pcplus     (de_pcplus),
      .de_op         (de_op),
      .de_type       (de_type),
      .de_imm        (de_imm),
      .de_rs1_val    (de_rs1_val),
      .de_rs2_val    (de_rs2_val),
      .de_rd         (de_rd),
      .de_wr_reg     (de_wr_reg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; fe_valid = 1'b0; fe_inst = '0; fe_pc = '0;
      agex_br_taken = 1'b0; wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
      tick(); tick();
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h exp 0", de_valid); end
      checks++; if (de_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %0h exp 0", de_inst); end
      checks++; if (de_imm !== 32'h0) begin errors++; $display("FAIL reset_imm: got %0h exp 0", de_imm); end
      checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h exp 0", de_stall); end
      checks++; if (dut.busy_q !== 32'h0) begin errors++; $display("FAIL reset_busy: got %0h exp 0", dut.busy_q); end
   endtask

   task automatic test_addi();
      reset = 1'b0; fe_valid = 1'b1; fe_inst = ADDI_X1_X0_5; fe_pc = 32'h100;
      #1;
      checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL addi_stall: got %0h exp 0", de_stall); end
      tick();
      checks++; if (de_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0h exp 1", de_valid); end
      checks++; if (de_op !== ADDI_I) begin errors++; $display("FAIL addi_op: got %0h exp %0h", de_op, ADDI_I); end
      checks++; if (de_type !== I_TYPE) begin errors++; $display("FAIL addi_type: got %0h exp %0h", de_type, I_TYPE); end
      checks++; if (de_imm !== 32'd5) begin errors++; $display("FAIL addi_imm: got %0h exp 5", de_imm); end
      checks++; if (de_rd !== 5'd1) begin errors++; $display("FAIL addi_rd: got %0h exp 1", de_rd); end
      checks++; if (de_wr_reg !== 1'b1) begin errors++; $display("FAIL addi_wr_reg: got %0h exp 1", de_wr_reg); end
      checks++; if (de_inst !== ADDI_X1_X0_5) begin errors++; $display("FAIL addi_inst: got %0h exp %0h", de_inst, ADDI_X1_X0_5); end
      checks++; if (de_pcplus !== 32'h104) begin errors++; $display("FAIL addi_pcplus: got %0h exp 104", de_pcplus); end
      checks++; if (dut.busy_q[1] !== 1'b1) begin errors++; $display("FAIL addi_busy1: got %0h exp 1", dut.busy_q[1]); end
   endtask

   task automatic test_raw_stall();
      fe_inst = ADD_X2_X1_X1; fe_pc = 32'h104;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (de_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_%0d: got %0h exp 1", i, de_stall); end
         tick();
         checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL raw_bubble_%0d: got %0h exp 0", i, de_valid); end
      end
      wb_wr_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
      #1;
      checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL raw_release: got %0h exp 0", de_stall); end
      tick();
      wb_wr_en = 1'b0;
      checks++; if (de_valid !== 1'b1) begin errors++; $display("FAIL raw_valid: got %0h exp 1", de_valid); end
      checks++; if (de_op !== ADD_I) begin errors++; $display("FAIL raw_op: got %0h exp %0h", de_op, ADD_I); end
      checks++; if (de_rs1_val !== 32'd5) begin errors++; $display("FAIL raw_rs1: got %0h exp 5", de_rs1_val); end
      checks++; if (de_rs2_val !== 32'd5) begin errors++; $display("FAIL raw_rs2: got %0h exp 5", de_rs2_val); end
      checks++; if (dut.busy_q[2:1] !== 2'b10) begin errors++; $display("FAIL raw_busy: got %0h exp 2", dut.busy_q[2:1]); end
   endtask

   task automatic test_squash();
      fe_inst = ADD_X6_X2_X2; agex_br_taken = 1'b1;
      #1;
      checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL squash_hazard_stall: got %0h exp 0", de_stall); end
      tick();
      fe_inst = ADDI_X3_X0_1;
      #1;
      checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL squash_stall: got %0h exp 0", de_stall); end
      tick();
      agex_br_taken = 1'b0;
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL squash_valid: got %0h exp 0", de_valid); end
      checks++; if (dut.busy_q[3] !== 1'b0) begin errors++; $display("FAIL squash_busy3: got %0h exp 0", dut.busy_q[3]); end
      checks++; if (dut.busy_q[2] !== 1'b1) begin errors++; $display("FAIL squash_older_busy2: got %0h exp 1", dut.busy_q[2]); end
      fe_inst = ADD_X6_X2_X2;
      #1;
      checks++; if (de_stall !== 1'b1) begin errors++; $display("FAIL post_squash_stall: got %0h exp 1", de_stall); end
      wb_wr_en = 1'b1; wb_rd = 5'd2; wb_data = 32'hA;
      #1;
      checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL bypass_release: got %0h exp 0", de_stall); end
      tick();
      wb_wr_en = 1'b0;
      checks++; if (de_rs1_val !== 32'hA) begin errors++; $display("FAIL bypass_rs1: got %0h exp a", de_rs1_val); end
      checks++; if (dut.busy_q[6] !== 1'b1) begin errors++; $display("FAIL bypass_busy6: got %0h exp 1", dut.busy_q[6]); end
   endtask

   task automatic test_x0();
      fe_inst = ADD_X7_X0_X0; wb_wr_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
      tick();
      wb_wr_en = 1'b0;
      checks++; if (de_rs1_val !== 32'h0) begin errors++; $display("FAIL x0_bypass_read: got %0h exp 0", de_rs1_val); end
      fe_inst = ADDI_X0_X0_1;
      tick();
      checks++; if (de_valid !== 1'b1) begin errors++; $display("FAIL x0_valid: got %0h exp 1", de_valid); end
      checks++; if (de_rs1_val !== 32'h0) begin errors++; $display("FAIL x0_read: got %0h exp 0", de_rs1_val); end
      checks++; if (de_wr_reg !== 1'b0) begin errors++; $display("FAIL x0_wr_reg: got %0h exp 0", de_wr_reg); end
      checks++; if (dut.busy_q[0] !== 1'b0) begin errors++; $display("FAIL x0_busy0: got %0h exp 0", dut.busy_q[0]); end
   endtask

   task automatic test_set_wins();
      fe_inst = ADDI_X4_X0_7; wb_wr_en = 1'b1; wb_rd = 5'd4; wb_data = 32'h99;
      tick();
      checks++; if (dut.busy_q[4] !== 1'b1) begin errors++; $display("FAIL set_wins_busy4: got %0h exp 1", dut.busy_q[4]); end
      checks++; if (de_rd !== 5'd4) begin errors++; $display("FAIL set_wins_rd: got %0h exp 4", de_rd); end
      fe_inst = ADD_X8_X4_X1; wb_rd = 5'd4; wb_data = 32'h77;
      #1;
      checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL wb_bypass_stall: got %0h exp 0", de_stall); end
      tick();
      wb_wr_en = 1'b0;
      checks++; if (de_rs1_val !== 32'h77) begin errors++; $display("FAIL wb_bypass_rs1: got %0h exp 77", de_rs1_val); end
      checks++; if (de_rs2_val !== 32'd5) begin errors++; $display("FAIL wb_bypass_rs2: got %0h exp 5", de_rs2_val); end
      checks++; if (dut.busy_q[4] !== 1'b0) begin errors++; $display("FAIL wb_clear_busy4: got %0h exp 0", dut.busy_q[4]); end
   endtask

   task automatic test_formats();
      fe_inst = BEQ_X1_X2_M8; fe_pc = 32'h200;
      tick();
      checks++; if (de_imm !== 32'hFFFF_FFF8) begin errors++; $display("FAIL beq_imm: got %0h exp fffffff8", de_imm); end
      checks++; if (de_wr_reg !== 1'b0) begin errors++; $display("FAIL beq_wr_reg: got %0h exp 0", de_wr_reg); end
      checks++; if (de_type !== B_TYPE) begin errors++; $display("FAIL beq_type: got %0h exp %0h", de_type, B_TYPE); end
      checks++; if (de_op !== BEQ_I) begin errors++; $display("FAIL beq_op: got %0h exp %0h", de_op, BEQ_I); end
      checks++; if (de_rs2_val !== 32'hA) begin errors++; $display("FAIL beq_rs2: got %0h exp a", de_rs2_val); end
      fe_inst = SW_X2_8_X1;
      tick();
      checks++; if (de_imm !== 32'd8) begin errors++; $display("FAIL sw_imm: got %0h exp 8", de_imm); end
      checks++; if (de_type !== S_TYPE) begin errors++; $display("FAIL sw_type: got %0h exp %0h", de_type, S_TYPE); end
      checks++; if (de_wr_reg !== 1'b0) begin errors++; $display("FAIL sw_wr_reg: got %0h exp 0", de_wr_reg); end
      fe_inst = LUI_X5_12345;
      tick();
      checks++; if (de_imm !== 32'h1234_5000) begin errors++; $display("FAIL lui_imm: got %0h exp 12345000", de_imm); end
      checks++; if (de_type !== U_TYPE) begin errors++; $display("FAIL lui_type: got %0h exp %0h", de_type, U_TYPE); end
      fe_inst = BAD_INST;
      tick();
      checks++; if (de_op !== NOP_I) begin errors++; $display("FAIL bad_op: got %0h exp %0h", de_op, NOP_I); end
      checks++; if (de_wr_reg !== 1'b0) begin errors++; $display("FAIL bad_wr_reg: got %0h exp 0", de_wr_reg); end
      checks++; if (dut.busy_q[31] !== 1'b0) begin errors++; $display("FAIL bad_busy31: got %0h exp 0", dut.busy_q[31]); end
      fe_valid = 1'b0;
      tick();
      checks++; if (de_valid !== 1'b0 || de_inst !== 32'h0) begin errors++; $display("FAIL idle_bubble: got %0h/%0h exp 0/0", de_valid, de_inst); end
   endtask

   task automatic test_reset_mid_stall();
      fe_valid = 1'b1; fe_inst = ADD_X9_X8_X8;
      #1;
      checks++; if (de_stall !== 1'b1) begin errors++; $display("FAIL mid_stall_pre: got %0h exp 1", de_stall); end
      reset = 1'b1;
      #1;
      checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL mid_stall_reset: got %0h exp 0", de_stall); end
      tick();
      checks++; if (de_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %0h exp 0", de_valid); end
      checks++; if (dut.busy_q !== 32'h0) begin errors++; $display("FAIL mid_reset_busy: got %0h exp 0", dut.busy_q); end
      reset = 1'b0; fe_inst = ADD_X10_X1_X1;
      #1;
      checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall: got %0h exp 0", de_stall); end
      tick();
      checks++; if (de_valid !== 1'b1 || de_rs1_val !== 32'h0) begin errors++; $display("FAIL post_reset_regs: got %0h/%0h exp 1/0", de_valid, de_rs1_val); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_raw_stall();
      test_squash();
      test_x0();
      test_set_wins();
      test_formats();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
